// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared fx bus widths, command codes and master FSM states
package fx_pkg;

  localparam int FX_AW = 22;
  localparam int FX_DW = 8;
  localparam int TO_W  = 17;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_A2,
    S_A1,
    S_A0,
    S_DAT,
    S_WR,
    S_RD,
    S_RWAIT,
    S_TXH,
    S_TXD
  } fx_state_t;

  // States in which the host is mid-frame and the inter-byte timeout runs.
  function automatic logic fx_in_frame(input fx_state_t s);
    return (s == S_CMD) || (s == S_A2) || (s == S_A1) || (s == S_A0) || (s == S_DAT);
  endfunction

endpackage

// File: rtl/fx_frame_timeout.sv
// rtl/fx_frame_timeout.sv - inter-byte timeout counter for the UART command frame
// Ports: clk_sys, rst (async, active-high), en (count while high, clears when low),
//        kick (clear on received byte), expire (counter reached TO_CYC-1 while enabled).
module fx_frame_timeout
  import fx_pkg::*;
#(
  parameter int TO_CYC = 100000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expire
);

  logic [TO_W-1:0] r_cnt;

  assign expire = en && (r_cnt == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || kick) begin
      r_cnt <= '0;
    end else if (!expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fx_master.sv
// rtl/uart_fx_master.sv - UART command-frame master driving the ufx_* bus port
// Ports: clk_sys/rst (async, active-high); rx_byte/rx_vld from UART receiver;
//        tx_byte/tx_vld/tx_rdy to UART transmitter; ufx_wr/ufx_waddr/ufx_data write port;
//        ufx_rd/ufx_raddr read port; ufx_q OR-combined read data; busy = FSM not idle.
// Build option: define FX_WR_ACK_EN to answer every write with HDR_RSP, 8'h00.
module uart_fx_master
  import fx_pkg::*;
#(
  parameter logic [7:0] HDR_REQ  = 8'hA5,
  parameter logic [7:0] HDR_RSP  = 8'h5A,
  parameter int         READ_LAT = 2,
  parameter int         TO_CYC   = 100000
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_vld,
  output logic [7:0]       tx_byte,
  output logic             tx_vld,
  input  logic             tx_rdy,
  output logic             ufx_wr,
  output logic [FX_DW-1:0] ufx_data,
  output logic [FX_AW-1:0] ufx_waddr,
  output logic             ufx_rd,
  output logic [FX_AW-1:0] ufx_raddr,
  input  logic [FX_DW-1:0] ufx_q,
  output logic             busy
);

  fx_state_t        r_state;
  logic             r_is_wr;
  logic [FX_AW-1:0] r_addr;
  logic [FX_DW-1:0] r_rdata;
  logic [2:0]       r_lat;
  logic             w_expire;
  logic             w_to_en;

  assign w_to_en = fx_in_frame(r_state);
  assign busy    = (r_state != S_IDLE);

  fx_frame_timeout #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clk_sys (clk_sys),
    .rst     (rst),
    .en      (w_to_en),
    .kick    (rx_vld),
    .expire  (w_expire)
  );

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_is_wr   <= 1'b0;
      r_addr    <= '0;
      r_rdata   <= '0;
      r_lat     <= '0;
      tx_byte   <= '0;
      tx_vld    <= 1'b0;
      ufx_wr    <= 1'b0;
      ufx_data  <= '0;
      ufx_waddr <= '0;
      ufx_rd    <= 1'b0;
      ufx_raddr <= '0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      ufx_wr <= 1'b0;
      ufx_rd <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (rx_vld && (rx_byte == HDR_REQ)) r_state <= S_CMD;
        end

        // Expiry is checked first so it wins over a coinciding rx_vld.
        S_CMD: begin
          if (w_expire) begin
            r_state <= S_IDLE;
          end else if (rx_vld) begin
            if (rx_byte == CMD_WR) begin
              r_is_wr <= 1'b1;
              r_state <= S_A2;
            end else if (rx_byte == CMD_RD) begin
              r_is_wr <= 1'b0;
              r_state <= S_A2;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_A2: begin
          if (w_expire) begin
            r_state <= S_IDLE;
          end else if (rx_vld) begin
            r_addr[21:16] <= rx_byte[5:0];
            r_state       <= S_A1;
          end
        end

        S_A1: begin
          if (w_expire) begin
            r_state <= S_IDLE;
          end else if (rx_vld) begin
            r_addr[15:8] <= rx_byte;
            r_state      <= S_A0;
          end
        end

        S_A0: begin
          if (w_expire) begin
            r_state <= S_IDLE;
          end else if (rx_vld) begin
            r_addr[7:0] <= rx_byte;
            r_state     <= r_is_wr ? S_DAT : S_RD;
          end
        end

        S_DAT: begin
          if (w_expire) begin
            r_state <= S_IDLE;
          end else if (rx_vld) begin
            ufx_data <= rx_byte;
            r_state  <= S_WR;
          end
        end

        S_WR: begin
          ufx_waddr <= r_addr;
          ufx_wr    <= 1'b1;
`ifdef FX_WR_ACK_EN
          r_rdata <= '0;
          tx_byte <= HDR_RSP;
          tx_vld  <= 1'b1;
          r_state <= S_TXH;
`else
          r_state <= S_IDLE;
`endif
        end

        S_RD: begin
          ufx_raddr <= r_addr;
          ufx_rd    <= 1'b1;
          r_lat     <= '0;
          r_state   <= S_RWAIT;
        end

        // r_lat is 0 on the ufx_rd cycle, so sampling at READ_LAT lands
        // exactly READ_LAT cycles after the strobe.
        S_RWAIT: begin
          if (r_lat == 3'(READ_LAT)) begin
            r_rdata <= ufx_q;
            tx_byte <= HDR_RSP;
            tx_vld  <= 1'b1;
            r_state <= S_TXH;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end

        S_TXH: begin
          if (tx_rdy) begin
            tx_byte <= r_rdata;
            r_state <= S_TXD;
          end
        end

        S_TXD: begin
          if (tx_rdy) begin
            tx_vld  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fx_master.sv
// tb/tb_uart_fx_master.sv - directed bench with transaction model and per-cycle monitor for uart_fx_master
module tb_uart_fx_master;

  localparam int READ_LAT = 2;
  localparam int TO_CYC   = 40;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_vld  = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_vld;
  logic        tx_rdy  = 1'b1;
  logic        ufx_wr;
  logic [7:0]  ufx_data;
  logic [21:0] ufx_waddr;
  logic        ufx_rd;
  logic [21:0] ufx_raddr;
  logic [7:0]  ufx_q   = 8'h00;
  logic        busy;

  uart_fx_master #(
    .HDR_REQ  (8'hA5),
    .HDR_RSP  (8'h5A),
    .READ_LAT (READ_LAT),
    .TO_CYC   (TO_CYC)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_vld    (rx_vld),
    .tx_byte   (tx_byte),
    .tx_vld    (tx_vld),
    .tx_rdy    (tx_rdy),
    .ufx_wr    (ufx_wr),
    .ufx_data  (ufx_data),
    .ufx_waddr (ufx_waddr),
    .ufx_rd    (ufx_rd),
    .ufx_raddr (ufx_raddr),
    .ufx_q     (ufx_q),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    logic [21:0] a;
    logic [7:0]  d;
    int          at;
  } bus_t;

  bus_t       exp_wr[$];
  bus_t       exp_rd[$];
  logic [7:0] exp_tx[$];

  int         q_due = -100;
  logic [7:0] q_val = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Address rule: A2 contributes only its low six bits.
  function automatic logic [21:0] model_addr(input logic [7:0] a2, a1, a0);
    int v;
    v = (int'(a2) % 64) * 65536 + int'(a1) * 256 + int'(a0);
    return v[21:0];
  endfunction

  // Slave: read data is visible only in the cycle READ_LAT after ufx_rd.
  always @(posedge clk_sys) begin
    #1;
    ufx_q = (cyc == q_due) ? q_val : 8'h00;
  end

  // Monitor: compare bus strobes and transmitter traffic against the model queues.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always @(negedge clk_sys) begin
    if (!rst) begin
      if (ufx_wr && ufx_rd) chk("wr_rd_overlap", 1, 0);
      if (ufx_wr) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          bus_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", ufx_waddr, e.a);
          chk("wr_data", ufx_data, e.d);
          chk("wr_latency", cyc, e.at);
        end
      end
      if (ufx_rd) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          bus_t e;
          e = exp_rd.pop_front();
          chk("rd_addr", ufx_raddr, e.a);
          chk("rd_latency", cyc, e.at);
          q_due = cyc + READ_LAT;
          q_val = e.d;
        end
      end
      if (prev_stall) begin
        chk("tx_vld_held", tx_vld, 1);
        chk("tx_byte_held", tx_byte, prev_byte);
      end
      if (tx_vld && tx_rdy) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_byte", tx_byte, exp_tx.pop_front());
      end
      prev_stall = tx_vld && !tx_rdy;
      prev_byte  = tx_byte;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int last_rx = 0;

  task automatic send(input logic [7:0] b);
    @(posedge clk_sys);
    #1;
    rx_byte = b;
    rx_vld  = 1'b1;
    last_rx = cyc;
    @(posedge clk_sys);
    #1;
    rx_vld  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a2, a1, a0, d);
    bus_t e;
    send(8'hA5); send(8'h01); send(a2); send(a1); send(a0); send(d);
    e.a = model_addr(a2, a1, a0);
    e.d = d;
    e.at = last_rx + 2;
    exp_wr.push_back(e);
`ifdef FX_WR_ACK_EN
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'h00);
`endif
  endtask

  task automatic do_read(input logic [7:0] a2, a1, a0, q, input bit expect_tx);
    bus_t e;
    send(8'hA5); send(8'h02); send(a2); send(a1); send(a0);
    e.a = model_addr(a2, a1, a0);
    e.d = q;
    e.at = last_rx + 2;
    exp_rd.push_back(e);
    if (expect_tx) begin
      exp_tx.push_back(8'h5A);
      exp_tx.push_back(q);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk_sys);
      #1;
      if (!busy && !tx_vld) done = 1;
    end
    chk(name, done, 1);
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_vld"}, tx_vld, 0);
    chk({tag, "_tx_byte"}, tx_byte, 0);
    chk({tag, "_ufx_wr"}, ufx_wr, 0);
    chk({tag, "_ufx_rd"}, ufx_rd, 0);
    chk({tag, "_ufx_waddr"}, ufx_waddr, 0);
    chk({tag, "_ufx_raddr"}, ufx_raddr, 0);
    chk({tag, "_ufx_data"}, ufx_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk_sys);

    // Basic write.
    do_write(8'h3F, 8'h12, 8'h34, 8'hC7);
    wait_idle("write_done");
    chk("lit_waddr", ufx_waddr, 22'h3F1234);
    chk("lit_wdata", ufx_data, 8'hC7);

    // Basic read with response.
    do_read(8'h00, 8'h00, 8'h10, 8'h9E, 1);
    wait_idle("read_done");
    chk("lit_raddr", ufx_raddr, 22'h000010);
    chk("lit_waddr_held", ufx_waddr, 22'h3F1234);

    // A2 top bits ignored; header value inside address is plain data.
    do_write(8'hFF, 8'hA5, 8'h5A, 8'h11);
    wait_idle("write2_done");
    chk("lit_waddr_mask", ufx_waddr, 22'h3FA55A);

    // Backpressure during the response.
    tx_rdy = 1'b0;
    do_read(8'h01, 8'h02, 8'h03, 8'h9E, 1);
    repeat (20) @(posedge clk_sys);
    #1;
    chk("bp_tx_vld", tx_vld, 1);
    chk("bp_tx_byte", tx_byte, 8'h5A);
    tx_rdy = 1'b1;
    wait_idle("bp_done");

    // Bad command, then a normal frame.
    send(8'hA5); send(8'h07);
    repeat (2) @(posedge clk_sys);
    #1;
    chk("badcmd_idle", busy, 0);
    do_write(8'h00, 8'hBE, 8'hEF, 8'h42);
    wait_idle("after_bad_done");

    // Inter-byte timeout boundary.
    send(8'hA5); send(8'h01); send(8'h00);
    repeat (TO_CYC - 2) @(posedge clk_sys);
    #1;
    chk("to_busy_before", busy, 1);
    repeat (2) @(posedge clk_sys);
    #1;
    chk("to_busy_after", busy, 0);
    send(8'h12);
    repeat (10) @(posedge clk_sys);
    #1;
    chk("to_stray_idle", busy, 0);

    // Reset in RWAIT: outputs clear at once, response abandoned.
    do_read(8'h02, 8'h04, 8'h06, 8'h77, 0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    chk("rst_in_rwait_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (3) @(posedge clk_sys);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk_sys);
    #1;

    chk("exp_wr_empty", exp_wr.size(), 0);
    chk("exp_rd_empty", exp_rd.size(), 0);
    chk("exp_tx_empty", exp_tx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
